// File: rtl/dumb_turing_loader.sv
// Loads a byte-streamed program into a Tiny-Tapeout style DUT over a STB/ACK
// handshake on ui/uio, then runs it until HALT and reports the 6-bit result.
module dumb_turing_loader #(
  parameter int RST_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 255,
  parameter int RUN_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       drv_rst_n,
  output logic       drv_ena,
  output logic [7:0] drv_ui,
  output logic [7:0] drv_uio,
  input  logic [7:0] mon_uo,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic [5:0] result,
  output logic [7:0] byte_cnt
);

  typedef enum logic [2:0] {
    IDLE, RSTDUT, SETTLE, FETCH, STB_HI, STB_LO, RUN, FIN
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] RUN_LAST = 16'(RUN_TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_ack_sync, r_halt_sync;
  logic        r_last, w_last_nxt;
  logic        w_ack, w_halt;
  logic [7:0]  w_ui_nxt, w_byte_cnt_nxt;
  logic [1:0]  w_err_nxt;
  logic [5:0]  w_result_nxt;

  assign w_ack  = r_ack_sync[1];
  assign w_halt = r_halt_sync[1];

  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_ui_nxt       = drv_ui;
    w_byte_cnt_nxt = byte_cnt;
    w_err_nxt      = err;
    w_result_nxt   = result;
    case (r_state)
      IDLE: if (start) begin
        w_state_nxt    = RSTDUT;
        w_err_nxt      = 2'd0;
        w_result_nxt   = 6'd0;
        w_byte_cnt_nxt = 8'd0;
      end
      RSTDUT: if (r_cnt == RST_LAST) w_state_nxt = SETTLE;
      SETTLE: begin
        // ACK already high before any strobe means the DUT is not our loader target
        if (w_ack) begin
          w_err_nxt   = 2'd3;
          w_state_nxt = FIN;
        end else if (r_cnt == 16'd1) begin
          w_state_nxt = FETCH;
        end
      end
      FETCH: if (s_valid && s_ready) begin
        w_ui_nxt    = s_data;
        w_last_nxt  = s_last;
        w_state_nxt = STB_HI;
      end
      STB_HI: begin
        if (w_ack) begin
          w_byte_cnt_nxt = byte_cnt + 8'd1;
          w_state_nxt    = STB_LO;
        end else if (r_cnt == ACK_LAST) begin
          w_err_nxt   = 2'd1;
          w_state_nxt = FIN;
        end
      end
      STB_LO: begin
        if (!w_ack) begin
          w_state_nxt = r_last ? RUN : FETCH;
        end else if (r_cnt == ACK_LAST) begin
          w_err_nxt   = 2'd1;
          w_state_nxt = FIN;
        end
      end
      RUN: begin
        if (w_halt) begin
          w_result_nxt = mon_uo[5:0];
          w_state_nxt  = FIN;
        end else if (r_cnt == RUN_LAST) begin
          w_err_nxt   = 2'd2;
          w_state_nxt = FIN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // cycle counter restarts on every state change; idle/fetch waits are unbounded
    if (w_state_nxt != r_state || r_state == IDLE || r_state == FETCH)
      w_cnt_nxt = 16'd0;
    else
      w_cnt_nxt = r_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 16'd0;
      r_last      <= 1'b0;
      r_ack_sync  <= 2'b00;
      r_halt_sync <= 2'b00;
      s_ready     <= 1'b0;
      drv_rst_n   <= 1'b0;
      drv_ena     <= 1'b0;
      drv_ui      <= 8'd0;
      drv_uio     <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 2'd0;
      result      <= 6'd0;
      byte_cnt    <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
      r_ack_sync  <= {r_ack_sync[0], mon_uo[7]};
      r_halt_sync <= {r_halt_sync[0], mon_uo[6]};
      // outputs are decoded from the next state so they line up with r_state
      s_ready     <= (w_state_nxt == FETCH);
      drv_rst_n   <= (w_state_nxt != RSTDUT);
      drv_ena     <= !(w_state_nxt inside {IDLE, FIN});
      busy        <= !(w_state_nxt inside {IDLE, FIN});
      done        <= (w_state_nxt == FIN);
      drv_uio     <= {w_state_nxt == STB_HI, w_state_nxt == RUN, 6'b0};
      drv_ui      <= w_ui_nxt;
      err         <= w_err_nxt;
      result      <= w_result_nxt;
      byte_cnt    <= w_byte_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_dumb_turing_loader.sv
// Scoreboard bench: stimulus queues expected session results and strobed bytes,
// monitors pop and compare on done pulses and STB rising edges.
module tb_dumb_turing_loader;

  typedef struct {
    logic [1:0] err;
    logic [5:0] res;
    logic [7:0] bc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       drv_rst_n;
  logic       drv_ena;
  logic [7:0] drv_ui;
  logic [7:0] drv_uio;
  logic [7:0] mon_uo;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [5:0] result;
  logic [7:0] byte_cnt;

  logic       ack, halt;
  logic [5:0] res;
  bit         ack_en = 1'b1, halt_en = 1'b1, ack_stuck = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  exp_t       exp_q[$];
  logic [7:0] ui_q[$];

  assign mon_uo = {ack, halt, res};

  dumb_turing_loader #(.RST_CYCLES(8), .ACK_TIMEOUT(255), .RUN_TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .drv_rst_n(drv_rst_n), .drv_ena(drv_ena),
    .drv_ui(drv_ui), .drv_uio(drv_uio), .mon_uo(mon_uo), .busy(busy), .done(done),
    .err(err), .result(result), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Simple DUT model: acks a strobe 3 cycles later, halts as soon as RUN is seen.
  initial begin : responder
    int dly;
    ack = 1'b0; halt = 1'b0; res = 6'h2A; dly = 0;
    forever begin
      @(posedge clk); #1;
      if (ack_stuck) ack = 1'b1;
      else if (!ack_en) ack = 1'b0;
      else if (drv_uio[7] && !ack) begin
        dly++;
        if (dly == 3) begin ack = 1'b1; dly = 0; end
      end else if (!drv_uio[7]) begin
        ack = 1'b0; dly = 0;
      end
      halt = halt_en && drv_uio[6];
    end
  end

  always @(negedge clk) begin : done_mon
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL done_unexpected: got done=1, expected no done pulse");
      end else begin
        e = exp_q.pop_front();
        chk("sess_err", 32'(err), 32'(e.err));
        chk("sess_result", 32'(result), 32'(e.res));
        chk("sess_byte_cnt", 32'(byte_cnt), 32'(e.bc));
        chk("sess_uio_dropped", 32'(drv_uio), 32'h0);
        chk("sess_busy_clear", 32'(busy), 32'h0);
      end
    end
  end

  always @(negedge clk) begin : ui_mon
    static logic stb_prev = 1'b0;
    logic [7:0] u;
    if (drv_uio[7] && !stb_prev) begin
      if (ui_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL ui_unexpected: got strobe of %0h, expected none", drv_ui);
      end else begin
        u = ui_q.pop_front();
        chk("ui_byte", 32'(drv_ui), 32'(u));
      end
    end
    stb_prev = drv_uio[7];
  end

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    ui_q.push_back(d);
    s_data = d; s_last = l; s_valid = 1'b1;
    while (!s_ready && t < 2000) begin @(negedge clk); t++; end
    if (!s_ready) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: got s_ready=0, expected 1 within 2000 cycles");
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 2000) begin @(negedge clk); t++; end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL %s: got no done, expected done within 2000 cycles", name);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst_n = 1'b0; start = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_drv_rst_n", 32'(drv_rst_n), 0);
    chk("rst_drv_ena", 32'(drv_ena), 0);
    chk("rst_drv_ui", 32'(drv_ui), 0);
    chk("rst_drv_uio", 32'(drv_uio), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_status", 32'({err, result, byte_cnt}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_drv_rst_n", 32'(drv_rst_n), 1);
    @(negedge clk);

    // nominal session plus reset/settle timing
    exp_q.push_back('{err: 2'd0, res: 6'h2A, bc: 8'd3});
    kick();
    chk("sess_busy", 32'(busy), 1);
    chk("sess_ena", 32'(drv_ena), 1);
    n = 0;
    while (!drv_rst_n && n < 100) begin n++; @(negedge clk); end
    chk("rstdut_cycles", 32'(n), 8);
    n = 0;
    while (drv_rst_n && !s_ready && n < 100) begin n++; @(negedge clk); end
    chk("settle_cycles", 32'(n), 2);
    chk("fetch_s_ready", 32'(s_ready), 1);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b1);
    wait_done("nominal_done");
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("fin_drv_rst_n", 32'(drv_rst_n), 1);
    chk("idle_result_hold", 32'(result), 32'h2A);

    // ack timeout: STB must stay high exactly ACK_TIMEOUT cycles
    ack_en = 1'b0;
    exp_q.push_back('{err: 2'd1, res: 6'h00, bc: 8'd0});
    kick();
    send(8'h9C, 1'b0);
    n = 0;
    while (drv_uio[7] && n < 1000) begin n++; @(negedge clk); end
    chk("ack_timeout_cycles", 32'(n), 255);
    chk("ack_timeout_done", 32'(done), 1);
    @(negedge clk);
    ack_en = 1'b1;

    // run timeout: RUN held exactly RUN_TIMEOUT cycles, result stays 0
    halt_en = 1'b0;
    exp_q.push_back('{err: 2'd2, res: 6'h00, bc: 8'd1});
    kick();
    send(8'h5A, 1'b1);
    n = 0;
    while (!drv_uio[6] && n < 100) begin n++; @(negedge clk); end
    n = 0;
    while (drv_uio[6] && n < 1000) begin n++; @(negedge clk); end
    chk("run_timeout_cycles", 32'(n), 100);
    chk("run_timeout_done", 32'(done), 1);
    @(negedge clk);
    halt_en = 1'b1;

    // protocol error: ACK high through SETTLE, byte offered but never taken
    ack_stuck = 1'b1;
    s_data = 8'hEE; s_last = 1'b1; s_valid = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back('{err: 2'd3, res: 6'h00, bc: 8'd0});
    kick();
    n = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      if (s_ready) n++;
      @(negedge clk);
    end
    chk("proto_no_ready", 32'(n), 0);
    chk("proto_done", 32'(done), 1);
    s_valid = 1'b0;
    ack_stuck = 1'b0;
    repeat (4) @(negedge clk);

    // abort mid STB_HI, then a clean session
    ack_en = 1'b0;
    kick();
    send(8'h77, 1'b0);
    repeat (2) @(negedge clk);
    chk("abort_in_stb_hi", 32'(drv_uio[7]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_uio", 32'(drv_uio), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ena", 32'(drv_ena), 0);
    chk("abort_drv_rst_n", 32'(drv_rst_n), 0);
    chk("abort_ui", 32'(drv_ui), 0);
    chk("abort_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back('{err: 2'd0, res: 6'h2A, bc: 8'd2});
    kick();
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b1);
    wait_done("restart_done");
    repeat (3) @(negedge clk);

    chk("sb_exp_empty", 32'(exp_q.size()), 0);
    chk("sb_ui_empty", 32'(ui_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dumb_turing_loader.md
DUMB_TURING_LOADER -- requirements
Module: dumb_turing_loader

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 8, meaning the number of cycles the DUT reset is held low (at least 1).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, meaning the maximum cycles to wait for any handshake edge (1..255).
REQ-003 SHALL have parameter RUN_TIMEOUT, default 65535, meaning the maximum cycles to wait for DUT halt (1..65535).
REQ-004 Ports:
  - clk, input, 1: the single clock.
  - rst_n, input, 1: asynchronous active-low reset.
  - start, input, 1: one-cycle request to begin a load/run session; honoured only in IDLE.
  - s_data, input, 8: program byte from the upstream source.
  - s_valid, input, 1: s_data is valid.
  - s_last, input, 1: qualifies the final program byte.
  - s_ready, output, 1: loader accepts s_data this cycle.
  - drv_rst_n, output, 1: reset driven to the DUT.
  - drv_ena, output, 1: enable driven to the DUT.
  - drv_ui, output, 8: drives the DUT ui_in.
  - drv_uio, output, 8: drives the DUT uio_in; bit7 = STB, bit6 = RUN, bits5:0 = 0.
  - mon_uo, input, 8: DUT uo_out; bit7 = ACK, bit6 = HALT, bits5:0 = RESULT.
  - busy, output, 1: session in progress.
  - done, output, 1: one-cycle pulse at session end.
  - err, output, 2: session status, 0 = ok, 1 = ack timeout, 2 = run timeout, 3 = protocol error (ACK high before STB).
  - result, output, 6: RESULT captured at halt.
  - byte_cnt, output, 8: bytes delivered this session.

Function
REQ-005 SHALL implement the state machine IDLE, RSTDUT, SETTLE, FETCH, STB_HI, STB_LO, RUN, FIN.
REQ-006 IDLE: start=1 SHALL move to RSTDUT, clear err/result/byte_cnt, and set busy; start in any other state SHALL be ignored.
REQ-007 RSTDUT SHALL hold drv_rst_n=0 for exactly RST_CYCLES cycles, then go to SETTLE.
REQ-008 SETTLE SHALL last 2 cycles with drv_rst_n=1 and then go to FETCH; ACK=1 seen in SETTLE SHALL set err=3 and go to FIN.
REQ-009 FETCH SHALL assert s_ready; on s_valid&s_ready it SHALL latch s_data into drv_ui, latch s_last, and go to STB_HI.
REQ-010 STB_HI SHALL drive STB=1 and wait for ACK=1; on ACK it SHALL increment byte_cnt (wrapping 255 to 0) and go to STB_LO.
REQ-011 STB_LO SHALL drive STB=0 and wait for ACK=0; it SHALL then go to RUN if the latched last is set, else to FETCH.
REQ-012 Every state that waits for an ACK edge SHALL count cycles; reaching ACK_TIMEOUT without the edge SHALL set err=1 and go to FIN.
REQ-013 RUN SHALL drive RUN=1 and wait for HALT=1; on halt it SHALL capture mon_uo[5:0] into result and go to FIN.
REQ-014 RUN SHALL set err=2 and go to FIN after RUN_TIMEOUT cycles without HALT.
REQ-015 FIN SHALL pulse done for 1 cycle, drop STB/RUN, clear busy, and return to IDLE; drv_rst_n SHALL stay 1 and result/err SHALL hold until the next start.
REQ-016 s_ready SHALL be 1 only in FETCH, so no byte is consumed outside FETCH.
REQ-017 ACK and HALT SHALL pass through a 2-flop synchronizer before use; handshake latency is counted on synchronized values.
REQ-018 drv_ena SHALL be 1 whenever busy=1 and 0 otherwise.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state IDLE and set: s_ready=0, drv_rst_n=0, drv_ena=0, drv_ui=0, drv_uio=0, busy=0, done=0, err=0, result=0, byte_cnt=0, counters=0, synchronizers=0.
REQ-021 After rst_n deasserts, drv_rst_n SHALL go to 1 on the first clock edge in IDLE.
REQ-022 Reset asserted mid-session SHALL abort with no done pulse.

Verification
REQ-023 Nominal: start, 3 bytes 0x12,0x34,0x56 (last on 0x56); responder acks each after 3 cycles; HALT with RESULT=0x2A -> drv_ui sequence 12/34/56, byte_cnt=3, result=0x2A, err=0, done pulses once.
REQ-024 Reset timing: start with RST_CYCLES=8 -> drv_rst_n low exactly 8 cycles, then SETTLE for 2 cycles, then s_ready=1.
REQ-025 Ack timeout: responder never raises ACK -> err=1 and done after ACK_TIMEOUT cycles in STB_HI, with STB dropped.
REQ-026 Run timeout: RUN_TIMEOUT=100, HALT never asserted -> err=2 at cycle 100 of RUN, result=0.
REQ-027 Protocol error: ACK held high through SETTLE -> err=3, byte_cnt=0, no byte consumed.
REQ-028 Abort: rst_n pulsed low during STB_HI -> all outputs at reset values immediately, no done pulse; a new start then runs normally.
